// File: rtl/reflet_8bit_bootloader_pkg.sv
// Shared types and constants for the reflet 8-bit UART bootloader.
package reflet_8bit_bootloader_pkg;

  localparam logic [7:0] BootMagic = 8'hA5;

  typedef enum logic [2:0] {
    StMagic,
    StLen,
    StData,
    StChk,
    StRun,
    StErr
  } boot_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/reflet_8bit_bootloader_uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid / framing-error pulses.
module reflet_8bit_bootloader_uart_rx
  import reflet_8bit_bootloader_pkg::*;
#(
  parameter int unsigned Div = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o
);

  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Div / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(Div - 1);

  logic [1:0]      sync_q;
  logic            prev_q;
  rx_state_e       st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RxIdle: begin
        if (prev_q && !rx_s) begin
          st_d  = RxStart;
          cnt_d = HalfM1;
        end
      end
      RxStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rx_s) begin
          // Start bit gone by mid-bit: treat as a glitch.
          st_d = RxIdle;
        end else begin
          st_d  = RxData;
          cnt_d = FullM1;
          bit_d = 3'd0;
        end
      end
      RxData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FullM1;
          if (bit_q == 3'd7) st_d = RxStop;
          else bit_d = bit_q + 3'd1;
        end
      end
      RxStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          valid_d = rx_s;
          ferr_d  = !rx_s;
          st_d    = RxIdle;
        end
      end
      default: st_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      st_q    <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte_o  = shift_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/reflet_8bit_bootloader.sv
// UART bootloader: loads A5/LEN/data[/CHK] into instruction RAM, then releases the CPU.
// Define REFLET_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module reflet_8bit_bootloader
  import reflet_8bit_bootloader_pkg::*;
#(
  parameter int unsigned ClkFreq  = 1000000,
  parameter int unsigned BaudRate = 9600,
  parameter int unsigned AddrSize = 7,
  parameter int unsigned MemSize  = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [AddrSize-1:0] mem_addr_o,
  output logic [7:0]          mem_data_o,
  output logic                mem_write_en_o,
  output logic                boot_active_o,
  output logic                cpu_reset_o,
  output logic                boot_error_o
);

  localparam int unsigned Div = ClkFreq / BaudRate;
  localparam int unsigned CntW = AddrSize + 1;
  localparam logic [8:0] MemSizeW = 9'(MemSize);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  reflet_8bit_bootloader_uart_rx #(
    .Div(Div)
  ) u_uart_rx (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rx_i      (rx_i),
    .rx_byte_o (rx_byte),
    .rx_valid_o(rx_valid),
    .rx_ferr_o (rx_ferr)
  );

  boot_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     len_q, len_d;
  logic [AddrSize-1:0] addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                we_q, we_d;
  logic                run_q, run_d;
`ifdef REFLET_BOOT_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    // Registered so the CPU is released the cycle after the final write strobe.
    run_d   = (state_q == StRun);
`ifdef REFLET_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      StMagic: begin
        if (rx_valid && rx_byte == BootMagic) state_d = StLen;
      end
      StLen: begin
        if (rx_ferr) begin
          state_d = StErr;
        end else if (rx_valid) begin
          if (rx_byte == 8'h00) begin
            state_d = StRun;
          end else if ({1'b0, rx_byte} > MemSizeW) begin
            state_d = StErr;
          end else begin
            state_d = StData;
            cnt_d   = '0;
            len_d   = CntW'(rx_byte);
`ifdef REFLET_BOOT_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
          end
        end
      end
      StData: begin
        if (rx_ferr) begin
          state_d = StErr;
        end else if (rx_valid) begin
          we_d   = 1'b1;
          addr_d = cnt_q[AddrSize-1:0];
          data_d = rx_byte;
          cnt_d  = cnt_q + CntW'(1);
`ifdef REFLET_BOOT_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
          if (cnt_q + CntW'(1) == len_q) state_d = StChk;
`else
          if (cnt_q + CntW'(1) == len_q) state_d = StRun;
`endif
        end
      end
`ifdef REFLET_BOOT_CHECKSUM_EN
      StChk: begin
        if (rx_ferr) begin
          state_d = StErr;
        end else if (rx_valid) begin
          state_d = (rx_byte == csum_q) ? StRun : StErr;
        end
      end
`endif
      StRun: begin
        addr_d = '0;
        data_d = 8'h00;
      end
      StErr: begin
        cnt_d   = '0;
        state_d = StMagic;
      end
      default: state_d = StMagic;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StMagic;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      run_q   <= run_d;
    end
  end

`ifdef REFLET_BOOT_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) csum_q <= 8'h00;
    else         csum_q <= csum_d;
  end
`endif

  assign mem_addr_o     = addr_q;
  assign mem_data_o     = data_q;
  assign mem_write_en_o = we_q;
  assign cpu_reset_o    = run_q;
  assign boot_active_o  = !run_q;
  assign boot_error_o   = (state_q == StErr);

endmodule

// File: tb/tb_reflet_8bit_bootloader.sv
// Directed, table-driven bench for the UART bootloader (DIV = 16).
module tb_reflet_8bit_bootloader;

  localparam int unsigned Div = 16;
  localparam int NV = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [6:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       boot_active;
  logic       cpu_reset;
  logic       boot_error;

  reflet_8bit_bootloader #(
    .ClkFreq (1000000),
    .BaudRate(62500),
    .AddrSize(7),
    .MemSize (128)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rx_i          (rx),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data),
    .mem_write_en_o(mem_we),
    .boot_active_o (boot_active),
    .cpu_reset_o   (cpu_reset),
    .boot_error_o  (boot_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  // Byte lists are packed with the first byte sent in bits [7:0].
  typedef struct {
    string       name;
    int          n;
    logic [63:0] b;
    logic [7:0]  bad_stop;
    int          exp_wr;
    logic [31:0] exp_d;
    logic        exp_run;
    int          exp_err;
  } vec_t;

  vec_t vecs[NV];
  wr_t  wr_q[$];
  int   err_cnt;
  int   cyc;
  int   last_we_cyc;
  int   run_cyc;
  bit   run_seen;
  int   n_pass = 0;
  int   n_total = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      wr_q.push_back('{addr: mem_addr, data: mem_data});
      last_we_cyc = cyc;
    end
    if (boot_error) err_cnt = err_cnt + 1;
    if (cpu_reset && !run_seen) begin
      run_seen = 1'b1;
      run_cyc  = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    wr_q.delete();
    err_cnt  = 0;
    run_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(Div);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(Div);
    end
    rx = stop;
    idle(Div);
    rx = 1'b1;
    idle(4);
  endtask

  task automatic set_vec(input int idx, input string name, input int n, input logic [63:0] b,
                         input logic [7:0] bad, input int exp_wr, input logic [31:0] exp_d,
                         input logic exp_run, input int exp_err);
    vecs[idx].name     = name;
    vecs[idx].n        = n;
    vecs[idx].b        = b;
    vecs[idx].bad_stop = bad;
    vecs[idx].exp_wr   = exp_wr;
    vecs[idx].exp_d    = exp_d;
    vecs[idx].exp_run  = exp_run;
    vecs[idx].exp_err  = exp_err;
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    cyc   = 0;
    err_cnt = 0;
    run_seen = 1'b0;
    last_we_cyc = 0;
    run_cyc = 0;

`ifdef REFLET_BOOT_CHECKSUM_EN
    set_vec(0, "stray_then_load3", 6, {8'h30, 8'h20, 8'h10, 8'h03, 8'hA5, 8'h11}, 8'h00,
            3, {8'h00, 8'h30, 8'h20, 8'h10}, 1'b0, 0);
    set_vec(2, "len_too_big", 5, {8'h42, 8'h01, 8'hA5, 8'h81, 8'hA5}, 8'h00,
            1, {24'h0, 8'h42}, 1'b0, 1);
`else
    set_vec(0, "stray_then_load3", 6, {8'h30, 8'h20, 8'h10, 8'h03, 8'hA5, 8'h11}, 8'h00,
            3, {8'h00, 8'h30, 8'h20, 8'h10}, 1'b1, 0);
    set_vec(2, "len_too_big", 5, {8'h42, 8'h01, 8'hA5, 8'h81, 8'hA5}, 8'h00,
            1, {24'h0, 8'h42}, 1'b1, 1);
`endif
    set_vec(1, "len_zero", 2, {8'h00, 8'hA5}, 8'h00, 0, 32'h0, 1'b1, 0);
    set_vec(3, "data_ferr", 3, {8'h55, 8'h02, 8'hA5}, 8'h04, 0, 32'h0, 1'b0, 1);
    set_vec(4, "short_load", 4, {8'h22, 8'h11, 8'h05, 8'hA5}, 8'h00,
            2, {16'h0, 8'h22, 8'h11}, 1'b0, 0);
    set_vec(5, "len_a5_err", 5, {8'h77, 8'h01, 8'hA5, 8'hA5, 8'h5A}, 8'h00,
            0, 32'h0, 1'b0, 1);

    // Reset values while reset is held, then a long idle period.
    idle(2);
    check("rst mem_addr", 32'(mem_addr), 32'h0);
    check("rst mem_data", 32'(mem_data), 32'h0);
    check("rst mem_we", 32'(mem_we), 32'h0);
    check("rst boot_active", 32'(boot_active), 32'h1);
    check("rst cpu_reset", 32'(cpu_reset), 32'h0);
    check("rst boot_error", 32'(boot_error), 32'h0);
    do_reset();
    idle(10000);
    check("idle writes", 32'(wr_q.size()), 32'h0);
    check("idle cpu_reset", 32'(cpu_reset), 32'h0);
    check("idle boot_active", 32'(boot_active), 32'h1);
    check("idle errors", 32'(err_cnt), 32'h0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte(vecs[v].b[8*i +: 8], !vecs[v].bad_stop[i]);
      end
      idle(8);
      check({vecs[v].name, " writes"}, 32'(wr_q.size()), 32'(vecs[v].exp_wr));
      for (int i = 0; i < vecs[v].exp_wr; i++) begin
        if (i < wr_q.size()) begin
          check($sformatf("%s addr%0d", vecs[v].name, i), 32'(wr_q[i].addr), 32'(i));
          check($sformatf("%s data%0d", vecs[v].name, i), 32'(wr_q[i].data),
                32'(vecs[v].exp_d[8*i +: 8]));
        end
      end
      check({vecs[v].name, " cpu_reset"}, 32'(cpu_reset), 32'(vecs[v].exp_run));
      check({vecs[v].name, " boot_active"}, 32'(boot_active), 32'(!vecs[v].exp_run));
      check({vecs[v].name, " errors"}, 32'(err_cnt), 32'(vecs[v].exp_err));
    end

`ifndef REFLET_BOOT_CHECKSUM_EN
    // Release timing, then traffic in RUN must be ignored.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    idle(4);
    check("release latency", 32'(run_cyc - last_we_cyc), 32'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(4);
    check("run ignores writes", 32'(wr_q.size()), 32'd2);
    check("run mem_addr", 32'(mem_addr), 32'h0);
    check("run mem_data", 32'(mem_data), 32'h0);
    check("run cpu_reset", 32'(cpu_reset), 32'h1);
`else
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(4);
    check("chk good run", 32'(cpu_reset), 32'h1);
    check("chk good errors", 32'(err_cnt), 32'h0);
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(4);
    check("chk bad errors", 32'(err_cnt), 32'h1);
    check("chk bad cpu_reset", 32'(cpu_reset), 32'h0);
    check("chk bad boot_active", 32'(boot_active), 32'h1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(4);
    check("chk back to magic", 32'(cpu_reset), 32'h1);
`endif

    // Short low glitch while loading must not produce a byte.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    idle(Div / 4);
    rx = 1'b1;
    idle(3 * Div);
    check("glitch no write", 32'(wr_q.size()), 32'h0);
    send_byte(8'h42, 1'b1);
    idle(4);
    check("post-glitch writes", 32'(wr_q.size()), 32'h1);
    if (wr_q.size() > 0) check("post-glitch data", 32'(wr_q[0].data), 32'h42);

    // Asynchronous reset mid-load, then a complete reload.
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("midload writes", 32'(wr_q.size()), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst mem_addr", 32'(mem_addr), 32'h0);
    check("midrst mem_data", 32'(mem_data), 32'h0);
    check("midrst boot_active", 32'(boot_active), 32'h1);
    check("midrst cpu_reset", 32'(cpu_reset), 32'h0);
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
`ifdef REFLET_BOOT_CHECKSUM_EN
    send_byte(8'h04, 1'b1);
`endif
    idle(4);
    check("reload writes", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) begin
      check("reload last addr", 32'(wr_q[3].addr), 32'd3);
      check("reload last data", 32'(wr_q[3].data), 32'h04);
    end
    check("reload cpu_reset", 32'(cpu_reset), 32'h1);
    check("reload boot_active", 32'(boot_active), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
